// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the
// unified memory port. slave = arbiter view, master = requester/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req, m0_we, m0_ack, m0_err;
  logic [1:0]        m0_mode;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;

  logic              m1_req, m1_we, m1_ack, m1_err;
  logic [1:0]        m1_mode;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;

  logic              mem_req, mem_we, mem_ready;
  logic [1:0]        mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic              busy, owner;

  modport slave (
    input  m0_req, m0_we, m0_mode, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_mode, m1_addr, m1_wdata,
    input  mem_rdata, mem_ready,
    output m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
    output mem_req, mem_we, mem_mode, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_mode, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_mode, m1_addr, m1_wdata,
    output mem_rdata, mem_ready,
    input  m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
    input  mem_req, mem_we, mem_mode, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the unified memory port.
// Port 0: CPU controller/datapath, port 1: loader/debug DMA.
// Optional ARB_TIMEOUT_EN: abort a BUSY transaction after TIMEOUT cycles
// without mem_ready, completing it with rdata=0 and err=1.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef struct packed {
    logic              we;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                  state;
  logic                    last_grant, owner_q, busy_q, mem_req_q, win;
  logic [1:0]              req_v, ack_q;
  logic [1:0][DATA_W-1:0]  rdata_q;
  req_t                    lat;
  req_t [1:0]              req_in;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
  logic [1:0]       err_q;
`endif

  assign req_v     = {bus.m1_req, bus.m0_req};
  assign req_in[0] = {bus.m0_we, bus.m0_mode, bus.m0_addr, bus.m0_wdata};
  assign req_in[1] = {bus.m1_we, bus.m1_mode, bus.m1_addr, bus.m1_wdata};

  // lone requester wins; on a tie the port not granted last time wins
  assign win = (&req_v) ? ~last_grant : req_v[1];

  // arbitration FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      lat        <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt        <= '0;
      err_q      <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q <= '0;
`endif
      case (state)
        IDLE: begin
          if (|req_v) begin
            lat        <= req_in[win];
            owner_q    <= win;
            last_grant <= win;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state      <= BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
          end
        end
        BUSY: begin
          // a ready arriving on the timeout cycle still completes normally
          if (bus.mem_ready) begin
            rdata_q[owner_q] <= lat.we ? '0 : bus.mem_rdata;
            ack_q[owner_q]   <= 1'b1;
            mem_req_q        <= 1'b0;
            state            <= RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            rdata_q[owner_q] <= '0;
            ack_q[owner_q]   <= 1'b1;
            err_q[owner_q]   <= 1'b1;
            mem_req_q        <= 1'b0;
            state            <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = lat.we;
  assign bus.mem_mode  = lat.mode;
  assign bus.mem_addr  = lat.addr;
  assign bus.mem_wdata = lat.wdata;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.m0_ack    = ack_q[0];
  assign bus.m1_ack    = ack_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
`ifdef ARB_TIMEOUT_EN
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
`else
  assign bus.m0_err    = 1'b0;
  assign bus.m1_err    = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for
// tie/reset/timeout, then randomized traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TB_TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int LONG_LAT = TB_TO - 1;
`else
  localparam int LONG_LAT = 5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  typedef struct {
    int          port;
    rq_t         f;
    logic [31:0] mrd;
    int          lat;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  task automatic drive(int p, logic r, rq_t f);
    if (p == 0) begin
      bus.m0_req = r; bus.m0_we = f.we; bus.m0_mode = f.mode;
      bus.m0_addr = f.addr; bus.m0_wdata = f.wdata;
    end else begin
      bus.m1_req = r; bus.m1_we = f.we; bus.m1_mode = f.mode;
      bus.m1_addr = f.addr; bus.m1_wdata = f.wdata;
    end
  endtask

  function automatic logic ack_of(int p);
    return (p == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction
  function automatic logic err_of(int p);
    return (p == 0) ? bus.m0_err : bus.m1_err;
  endfunction
  function automatic logic [31:0] rd_of(int p);
    return (p == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction
  function automatic logic fields_ok(rq_t f);
    return (bus.mem_we === f.we) && (bus.mem_mode === f.mode) &&
           (bus.mem_addr === f.addr) && (bus.mem_wdata === f.wdata);
  endfunction

  // one isolated transaction: grant latency, field stability, ack timing, hold
  task automatic do_txn(vec_t v);
    drive(v.port, 1'b1, v.f);
    @(negedge clk);
    chk({v.name, " grant"}, {bus.mem_req, bus.owner, bus.busy}, {1'b1, v.port[0], 1'b1});
    chk({v.name, " fields"}, fields_ok(v.f), 1);
    for (int i = 0; i < v.lat; i++) begin
      @(negedge clk);
      chk({v.name, " stable"}, bus.mem_req && fields_ok(v.f) && !bus.m0_ack && !bus.m1_ack, 1);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = v.mrd;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0BAD_F00D;
    chk({v.name, " ack"}, {ack_of(v.port), ack_of(1 - v.port), bus.mem_req, err_of(v.port)}, 4'b1000);
    chk({v.name, " rdata"}, rd_of(v.port), v.exp_rd);
    drive(v.port, 1'b0, v.f);
    @(negedge clk);
    chk({v.name, " ack_end"}, {ack_of(v.port), bus.busy}, 2'b00);
    chk({v.name, " hold"}, rd_of(v.port), v.exp_rd);
  endtask

  vec_t vecs[5];
  rq_t  fa, fb, pf[2];
  logic [1:0]  pend, prev_req, got_ack;
  logic [31:0] exp_rd[2], rd_val;
  logic        exp_last;
  bit          idle_prev, in_busy, ready_sent;
  int          cur, w, bw, n, bad;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    fa = '{we: 1'b0, mode: 2'b00, addr: 32'h0, wdata: 32'h0};
    drive(0, 1'b0, fa);
    drive(1, 1'b0, fa);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    vecs[0] = '{0, '{1'b0, 2'b00, 32'h0000_0010, 32'h0}, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, "m0_read"};
    vecs[1] = '{1, '{1'b1, 2'b01, 32'h0000_0023, 32'h0000_00A5}, 32'h1234_5678, 1, 32'h0, "m1_bytestore"};
    vecs[2] = '{0, '{1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0}, 32'h0000_00FF, LONG_LAT, 32'h0000_00FF, "m0_longlat"};
    vecs[3] = '{1, '{1'b0, 2'b01, 32'h0000_0080, 32'h0}, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, "m1_read"};
    vecs[4] = '{0, '{1'b1, 2'b00, 32'h0000_0100, 32'h55AA_55AA}, 32'h1111_1111, 0, 32'h0, "m0_write"};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", {bus.mem_req, bus.mem_we, bus.mem_mode, bus.busy, bus.owner,
                      bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 0);
    chk("reset_addr", {bus.mem_addr, bus.mem_wdata}, 0);
    chk("reset_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);

    // tie right after reset: both held high -> owners 0,1,0
    fa = '{we: 1'b0, mode: 2'b00, addr: 32'h0000_1000, wdata: 32'h0};
    fb = '{we: 1'b0, mode: 2'b00, addr: 32'h0000_2000, wdata: 32'h0};
    reset = 1'b0;
    drive(0, 1'b1, fa);
    drive(1, 1'b1, fb);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.mem_req && n < 10);
      chk("tie_owner", {bus.mem_req, bus.owner}, {1'b1, 1'(i % 2)});
      chk("tie_fields", fields_ok((i % 2) ? fb : fa), 1);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'(i + 1);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("tie_ack", {ack_of(i % 2), ack_of(1 - i % 2)}, 2'b10);
      if (i == 2) begin drive(0, 1'b0, fa); drive(1, 1'b0, fb); end
    end
    @(negedge clk);

    foreach (vecs[i]) do_txn(vecs[i]);

    // reset while BUSY drops the transaction
    drive(0, 1'b1, vecs[0].f);
    @(negedge clk);
    chk("rstbusy_grant", bus.mem_req, 1);
    reset = 1'b1;
    drive(0, 1'b0, vecs[0].f);
    @(negedge clk);
    chk("rstbusy_clear", {bus.mem_req, bus.busy, bus.m0_ack, bus.m1_ack}, 0);
    reset = 1'b0;
    do_txn(vecs[3]);

    // stalled memory
    do_txn('{0, '{1'b0, 2'b00, 32'h40, 32'h0}, 32'h7777_7777, 0, 32'h7777_7777, "m0_pre_to"});
    drive(0, 1'b1, vecs[0].f);
    @(negedge clk);
    chk("to_grant", bus.mem_req, 1);
`ifdef ARB_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.m0_ack && n < 20);
    chk("to_latency", n, TB_TO);
    chk("to_ack_err", {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err}, 4'b1100);
    chk("to_rdata", bus.m0_rdata, 0);
    drive(0, 1'b0, vecs[0].f);
    @(negedge clk);
    chk("to_err_end", {bus.m0_ack, bus.m0_err}, 0);
`else
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.busy || !bus.mem_req || bus.m0_ack || bus.m1_ack) bad++;
    end
    chk("no_timeout_wait", bad, 0);
    chk("no_timeout_hold", bus.m0_rdata, 32'h7777_7777);
`endif

    // randomized traffic against a transaction-level model
    reset = 1'b1;
    drive(0, 1'b0, fa);
    drive(1, 1'b0, fb);
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pend = '0; prev_req = '0; exp_last = 1'b1;
    idle_prev = 1; in_busy = 0; ready_sent = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    cur = 0; bw = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      got_ack = {bus.m1_ack, bus.m0_ack};
      if (idle_prev) begin
        if (prev_req != 2'b00) begin
          w = (prev_req == 2'b11) ? (exp_last ? 0 : 1) : (prev_req[1] ? 1 : 0);
          chk("rnd_grant", {bus.mem_req, bus.busy, bus.owner, got_ack}, {1'b1, 1'b1, w[0], 2'b00});
          chk("rnd_fields", fields_ok(pf[w]), 1);
          exp_last = w[0]; cur = w;
          in_busy = 1; idle_prev = 0; bw = 0;
        end else begin
          chk("rnd_idle", {bus.mem_req, bus.busy, got_ack}, 0);
        end
      end else if (in_busy) begin
        if (ready_sent) begin
          chk("rnd_ack", {got_ack, bus.mem_req, bus.busy}, {(cur != 0) ? 2'b10 : 2'b01, 1'b0, 1'b1});
          exp_rd[cur] = pf[cur].we ? 32'h0 : rd_val;
          in_busy = 0;
          pend[cur] = 1'b0;
        end else begin
          chk("rnd_wait", {bus.mem_req, bus.busy, bus.owner, got_ack, fields_ok(pf[cur])},
              {1'b1, 1'b1, cur[0], 2'b00, 1'b1});
          bw++;
        end
      end else begin
        chk("rnd_release_idle", {bus.mem_req, bus.busy, got_ack}, 0);
        idle_prev = 1;
      end
      chk("rnd_rdata0", bus.m0_rdata, exp_rd[0]);
      chk("rnd_rdata1", bus.m1_rdata, exp_rd[1]);
      chk("rnd_err", {bus.m0_err, bus.m1_err}, 0);

      // memory: real responses while busy, ignored noise otherwise
      rd_val = $urandom;
      bus.mem_rdata = rd_val;
      if (in_busy) ready_sent = (bw >= 2) || ($urandom % 3 == 0);
      else ready_sent = 0;
      bus.mem_ready = in_busy ? ready_sent : ($urandom % 4 == 0);

      // requesters
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom % 3 == 0)) begin
          pf[p].we    = 1'($urandom);
          pf[p].mode  = 2'($urandom_range(0, 2));
          pf[p].addr  = $urandom;
          pf[p].wdata = $urandom;
          pend[p]     = 1'b1;
        end
        drive(p, pend[p], pf[p]);
      end
      prev_req = pend;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: port 0 (the CPU multicycle controller/datapath, for fetch, load and store) and port 1 (the program loader/debug DMA).
- Grants one transaction at a time with round-robin fairness.
- Latches the granted request's address, data and mode, and drives the memory with a req/ready handshake.
- Returns read data and a one-cycle ack to the winner.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, cycles in BUSY without mem_ready before abort (only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_req  in  1  port 0 request; held high with stable fields until m0_ack
- m0_we  in  1  port 0 write enable
- m0_mode  in  2  00 word, 01 signed byte, 10 unsigned byte
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_rdata  out  DATA_W  port 0 read data, valid while m0_ack=1
- m0_ack  out  1  port 0 completion pulse
- m0_err  out  1  port 0 timeout flag, valid with m0_ack
- m1_req, m1_we, m1_mode, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as port 0, for port 1
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_mode  out  2  memory access mode
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle
- busy  out  1  high in BUSY and RELEASE
- owner  out  1  port currently or last granted

Behaviour:
- Reset: state=IDLE; last_grant=1 so port 0 wins the first tie. All outputs 0, including the mem_* fields, acks, errs, rdata, busy and owner.
- IDLE:
  - Sample m0_req/m1_req. If only one is high, that port wins; if both, the port != last_grant wins.
  - On a win: latch we/mode/addr/wdata of the winner, set owner and last_grant, go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_req=1; mem_* driven from the latched registers, stable for the whole state.
  - Requester inputs are ignored in this state.
  - On mem_ready: register mem_rdata (reads; 0 for writes) into the owner's rdata and go to RELEASE.
- RELEASE: the owner's ack=1 for exactly one cycle with rdata valid, mem_req=0, then go to IDLE.
- Rdata hold: rdata holds its value after ack until the next completion for that port.
- The non-owner's ack and err stay 0 throughout.
- Latency: req high at edge k in IDLE → mem_req high from cycle k+1. mem_ready sampled at edge n → ack high in cycle n+1. Minimum req-to-ack is 3 cycles.
- Requester rule: deassert req, or present a new request, by the edge that ends the ack cycle. A req still high in IDLE is treated as a new request.
- Back-to-back: continuous requests on both ports alternate strictly 0,1,0,1. A single continuous requester gets every slot.
- mem_ready in IDLE or RELEASE is ignored.
- mode passes through unchanged; the memory performs byte extension. mem_we=1 with mode 01 is a byte store.
- Reset mid-operation (any state): next cycle state=IDLE, mem_req=0. No ack is issued and the transaction is dropped.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT, go to RELEASE with owner's rdata=0 and err=1 alongside ack.
  - mem_ready in the same cycle as the timeout wins: normal completion, err=0.
- Not defined: no counter, BUSY waits indefinitely, m0_err/m1_err tied 0.

Test Plan:
- m0 read: m0_req=1, addr=0x00000010, mode=00; mem_ready one cycle after mem_req with rdata=0xDEADBEEF → mem_addr=0x10, m0_ack one-cycle pulse with m0_rdata=0xDEADBEEF, m1_ack=0.
- Tie after reset: m0_req and m1_req raised together, both held high → port 0 served first, then port 1, then port 0. owner sequence 0,1,0.
- Byte store via port 1: m1_we=1, mode=01, addr=0x23, wdata=0x000000A5 → mem_we=1, mem_mode=01, fields stable until mem_ready, m1_ack pulse.
- mem_ready held low for 5 cycles → mem_req and fields stable for all 5 cycles. The ack arrives exactly 1 cycle after mem_ready.
- reset asserted in BUSY → next cycle mem_req=0, busy=0, no ack. Subsequent m1 request served normally.
- ARB_TIMEOUT_EN, TIMEOUT=4, mem_ready never asserted → m0_ack with m0_err=1 and m0_rdata=0 after 4 BUSY cycles. Without the macro, busy stays high and no ack is issued.
